dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate slice. Successor to the fixed 18x18/48-bit DSP slice.
- Generic A/B/P widths, an optional pre-adder and a valid/ready stream interface with full back-pressure.
- Hardware accumulation-length counter: one result is emitted per group of ACC_LEN products.
- Optional saturation with an overflow flag. Sits between sample streams and the filter/correlator datapaths.

Parameters:
A_WIDTH, 18, signed width of A
B_WIDTH, 18, signed width of B and D (pre-adder operands)
P_WIDTH, 48, signed accumulator/result width; must be >= A_WIDTH+B_WIDTH+1
ACC_LEN_W, 8, width of ACC_LEN / group counter
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all logic on rising edge
RSTN  in  1  synchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  input sample accepted when in_valid & in_ready
A  in  A_WIDTH  signed multiplicand
B  in  B_WIDTH  signed multiplier / pre-adder operand
D  in  B_WIDTH  signed pre-adder operand
MODE  in  3  [0] preadd_en, [1] preadd_sub (D-B else D+B), [2] acc_sub (subtract product)
ACC_LEN  in  ACC_LEN_W  products per group; 0 treated as 1; sampled on a group's first sample
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accept
P  out  P_WIDTH  signed accumulated result
OVF  out  1  group overflowed (saturated or wrapped); qualified by out_valid

Behaviour:
- Reset: one clock; reset is synchronous and active-low (RSTN sampled on clk rising edge).
  - While RSTN=0, all pipeline registers, valid bits, counter and accumulator are cleared.
  - Outputs: out_valid=0, P=0, OVF=0, in_ready=0.
  - in_ready=1 from the first cycle after release.
  - A reset mid-group discards the partial accumulation; the next accepted sample starts a new group.
- Stall: stall = out_valid & ~out_ready; in_ready = RSTN & ~stall. While stall=1, every pipeline stage holds.
- Pipeline stages, each carrying a valid bit plus MODE/ACC_LEN tags:
  - S1: register A, B, D, MODE, ACC_LEN.
  - S2: pre = preadd_en ? (D±B) : B, sign-extended to B_WIDTH+1; A delayed.
  - S3: M = A*pre, width A_WIDTH+B_WIDTH+1, signed.
  - S4: accumulate.
- Accumulator:
  - First product of a group: acc = ±M (sign-extended); cnt=1; latch len = max(ACC_LEN,1).
  - Later products: acc = acc ± M; cnt++.
  - When the product making cnt==len is accumulated, load P=acc_next and OVF, set out_valid, clear cnt. The next product starts a new group.
- Latency: the last sample of a group is accepted at cycle t; out_valid=1 at t+4 (no stall).
- Throughput: one sample per clock. Groups are back-to-back with no bubble, including len=1.
- Overflow:
  - Detect using a P_WIDTH+1 sum whose top two bits differ.
  - SATURATE=1: clamp to +2^(P_WIDTH-1)-1 or -2^(P_WIDTH-1), and keep the saturated value for the rest of the group.
  - SATURATE=0: wrap.
  - Either mode: sticky group OVF is set, and cleared at group start.
- Output hold: P/OVF stay stable while out_valid & ~out_ready. out_valid drops the cycle after the handshake unless a new result is produced that same cycle.
- ACC_LEN/MODE changes mid-group: MODE applies per sample; ACC_LEN is ignored until the next group start.

Test Plan:
- ACC_LEN=1, MODE=000, A=3, B=5, out_ready=1 -> P=15, OVF=0, out_valid exactly 4 cycles after accept.
- ACC_LEN=1, MODE=011, D=10, B=4, A=-2 -> P=-12; MODE=001 same operands -> P=-28.
- ACC_LEN=4, A=1,2,3,4, B=2, streamed back-to-back; then ACC_LEN=1 A=7 B=1 -> P=20 then P=7 on consecutive output cycles, one out_valid pulse each.
- Override P_WIDTH=37, ACC_LEN=8, A=B=131071 x8 -> SATURATE=1: P=68719476735, OVF=1; SATURATE=0: wrapped value, OVF=1.
- out_ready low 3 cycles while streaming ACC_LEN=1 A=i B=1 (i=1..10) -> in_ready=0 during stall, P held, all 10 results (1..10) delivered in order with none lost or duplicated.
- RSTN=0 for 1 cycle after 2 of 4 samples in an ACC_LEN=4 group -> out_valid=0, P=0; next group A=1..4, B=1 -> P=10.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-accumulate slice: S1 input registers, S2 pre-adder,
// S3 multiplier, S4 grouped accumulator with optional saturation and sticky overflow.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int ACC_LEN_W = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                       clk,
  input  logic                       RSTN,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [A_WIDTH-1:0]  A,
  input  logic signed [B_WIDTH-1:0]  B,
  input  logic signed [B_WIDTH-1:0]  D,
  input  logic [2:0]                 MODE,
  input  logic [ACC_LEN_W-1:0]       ACC_LEN,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [P_WIDTH-1:0]  P,
  output logic                       OVF
);
  localparam int PRE_W = B_WIDTH + 1;
  localparam int M_W   = A_WIDTH + B_WIDTH + 1;
  localparam int SUM_W = P_WIDTH + 1;
  localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
  // out_valid/P/OVF never depend on out_ready combinationally; a stalled result
  // holds every pipeline stage, and in_ready drops for the stall cycles.
  logic stall;
  logic adv;

  // S1: registered inputs
  logic                      s1_valid_q, s1_valid_d;
  logic signed [A_WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [B_WIDTH-1:0] s1_b_q, s1_b_d;
  logic signed [B_WIDTH-1:0] s1_d_q, s1_d_d;
  logic [2:0]                s1_mode_q, s1_mode_d;
  logic [ACC_LEN_W-1:0]      s1_len_q, s1_len_d;

  // S2: pre-adder result, A delayed
  logic                      s2_valid_q, s2_valid_d;
  logic signed [A_WIDTH-1:0] s2_a_q, s2_a_d;
  logic signed [PRE_W-1:0]   s2_pre_q, s2_pre_d;
  logic                      s2_sub_q, s2_sub_d;
  logic [ACC_LEN_W-1:0]      s2_len_q, s2_len_d;

  // S3: product
  logic                      s3_valid_q, s3_valid_d;
  logic signed [M_W-1:0]     s3_m_q, s3_m_d;
  logic                      s3_sub_q, s3_sub_d;
  logic [ACC_LEN_W-1:0]      s3_len_q, s3_len_d;

  // S4: group accumulator and output register
  logic signed [P_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_LEN_W-1:0]      cnt_q, cnt_d;
  logic [ACC_LEN_W-1:0]      len_q, len_d;
  logic                      grp_ovf_q, grp_ovf_d;
  logic                      sat_hold_q, sat_hold_d;
  logic signed [P_WIDTH-1:0] p_q, p_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [PRE_W-1:0]   b_ext, d_ext;
  logic                      first;
  logic [ACC_LEN_W-1:0]      len_eff, cnt_inc;
  logic signed [SUM_W-1:0]   base_ext, m_ext, sum;
  logic                      sum_ovf, hold_now, hold_next, grp_ovf_next;
  logic signed [P_WIDTH-1:0] acc_next;

  always_comb begin
    stall    = out_valid_q & ~out_ready;
    adv      = ~stall;
    in_ready = RSTN & ~stall;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_d_d     = s1_d_q;
    s1_mode_d  = s1_mode_q;
    s1_len_d   = s1_len_q;
    if (adv) begin
      s1_valid_d = in_valid & in_ready;
      s1_a_d     = A;
      s1_b_d     = B;
      s1_d_d     = D;
      s1_mode_d  = MODE;
      s1_len_d   = ACC_LEN;
    end
  end

  always_comb begin
    b_ext      = PRE_W'(s1_b_q);
    d_ext      = PRE_W'(s1_d_q);
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_pre_d   = s2_pre_q;
    s2_sub_d   = s2_sub_q;
    s2_len_d   = s2_len_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_a_d     = s1_a_q;
      if (s1_mode_q[0]) begin
        s2_pre_d = s1_mode_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
      end else begin
        s2_pre_d = b_ext;
      end
      s2_sub_d   = s1_mode_q[2];
      s2_len_d   = s1_len_q;
    end
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_m_d     = s3_m_q;
    s3_sub_d   = s3_sub_q;
    s3_len_d   = s3_len_q;
    if (adv) begin
      s3_valid_d = s2_valid_q;
      s3_m_d     = M_W'(s2_a_q) * M_W'(s2_pre_q);
      s3_sub_d   = s2_sub_q;
      s3_len_d   = s2_len_q;
    end
  end

  // A zero count marks the first product of a group: history is ignored and ACC_LEN is latched.
  always_comb begin
    first   = (cnt_q == '0);
    len_eff = len_q;
    cnt_inc = cnt_q + ACC_LEN_W'(1);
    if (first) begin
      len_eff = (s3_len_q == '0) ? ACC_LEN_W'(1) : s3_len_q;
      cnt_inc = ACC_LEN_W'(1);
    end
    if (first) begin
      base_ext = '0;
    end else begin
      base_ext = SUM_W'(acc_q);
    end
    m_ext    = SUM_W'(s3_m_q);
    sum      = s3_sub_q ? (base_ext - m_ext) : (base_ext + m_ext);
    sum_ovf  = sum[SUM_W-1] ^ sum[SUM_W-2];
    hold_now = SATURATE && sat_hold_q && !first;

    if (hold_now) begin
      acc_next  = acc_q;
      hold_next = 1'b1;
    end else if (SATURATE && sum_ovf) begin
      acc_next  = sum[SUM_W-1] ? P_MIN : P_MAX;
      hold_next = 1'b1;
    end else begin
      acc_next  = sum[P_WIDTH-1:0];
      hold_next = 1'b0;
    end
    grp_ovf_next = (first ? 1'b0 : grp_ovf_q) | (sum_ovf & ~hold_now);
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    grp_ovf_d   = grp_ovf_q;
    sat_hold_d  = sat_hold_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (adv && s3_valid_q) begin
      acc_d      = acc_next;
      grp_ovf_d  = grp_ovf_next;
      sat_hold_d = hold_next;
      len_d      = len_eff;
      if (cnt_inc == len_eff) begin
        cnt_d       = '0;
        p_d         = acc_next;
        ovf_d       = grp_ovf_next;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_d_q      <= '0;
      s1_mode_q   <= '0;
      s1_len_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_pre_q    <= '0;
      s2_sub_q    <= 1'b0;
      s2_len_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_m_q      <= '0;
      s3_sub_q    <= 1'b0;
      s3_len_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      grp_ovf_q   <= 1'b0;
      sat_hold_q  <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_d_q      <= s1_d_d;
      s1_mode_q   <= s1_mode_d;
      s1_len_q    <= s1_len_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_pre_q    <= s2_pre_d;
      s2_sub_q    <= s2_sub_d;
      s2_len_q    <= s2_len_d;
      s3_valid_q  <= s3_valid_d;
      s3_m_q      <= s3_m_d;
      s3_sub_q    <= s3_sub_d;
      s3_len_q    <= s3_len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      grp_ovf_q   <= grp_ovf_d;
      sat_hold_q  <= sat_hold_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign P         = p_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: three instances (48-bit saturating, 37-bit saturating,
// 37-bit wrapping) share one stimulus stream and are checked against a group-sum model.
module tb_dsp_mac_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic              in_valid;
  logic              out_ready;
  logic signed [17:0] a_in, b_in, d_in;
  logic [2:0]        mode_in;
  logic [7:0]        len_in;
  logic              ir0, ir1, ir2;
  logic              ov0, ov1, ov2;
  logic              ovf0, ovf1, ovf2;
  logic signed [47:0] p0;
  logic signed [36:0] p1, p2;

  dsp_mac_pipe u_dut (
    .clk(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(ir0),
    .A(a_in), .B(b_in), .D(d_in), .MODE(mode_in), .ACC_LEN(len_in),
    .out_valid(ov0), .out_ready(out_ready), .P(p0), .OVF(ovf0)
  );

  dsp_mac_pipe #(.P_WIDTH(37), .SATURATE(1'b1)) u_sat37 (
    .clk(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(ir1),
    .A(a_in), .B(b_in), .D(d_in), .MODE(mode_in), .ACC_LEN(len_in),
    .out_valid(ov1), .out_ready(out_ready), .P(p1), .OVF(ovf1)
  );

  dsp_mac_pipe #(.P_WIDTH(37), .SATURATE(1'b0)) u_wrap37 (
    .clk(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(ir2),
    .A(a_in), .B(b_in), .D(d_in), .MODE(mode_in), .ACC_LEN(len_in),
    .out_valid(ov2), .out_ready(out_ready), .P(p2), .OVF(ovf2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic [64:0] exp_q2[$];
  longint      obs_p_q[$];
  bit          obs_ovf_q[$];
  int          obs_cyc_q[$];
  longint      last_p1, last_p2;
  bit          last_ovf1, last_ovf2;

  // reference model: one running sum per instance for the current group
  int     pw [3] = '{48, 37, 37};
  bit     satv [3] = '{1'b1, 1'b1, 1'b0};
  bit     in_grp = 1'b0;
  int     grp_len = 0;
  int     grp_cnt = 0;
  longint m_acc [3];
  bit     m_ovf [3];
  bit     m_held [3];
  longint m_pre, m_prod, m_sum;
  logic [64:0] e0;
  bit     rnd_done;

  function automatic longint pmax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint pmin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic longint wrapw(input longint s, input int w);
    longint r;
    r = s & ((64'sd1 <<< w) - 64'sd1);
    if (r > pmax(w)) r = r - (64'sd1 <<< w);
    return r;
  endfunction

  function automatic int rnd18();
    logic [17:0] v;
    case ($urandom_range(0, 5))
      0:       v = 18'h1ffff;
      1:       v = 18'h20000;
      default: v = 18'($urandom);
    endcase
    return int'($signed(v));
  endfunction

  task automatic check64(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // model update on accepted samples, scoreboard compare on output handshakes
  always @(negedge clk) begin
    check64("in_ready_match", {ir1, ir2}, {ir0, ir0});
    if (!rstn) begin
      in_grp = 1'b0;
    end else if (in_valid && ir0) begin
      last_acc_cyc = cyc;
      if (mode_in[0])
        m_pre = mode_in[1] ? (longint'(d_in) - longint'(b_in)) : (longint'(d_in) + longint'(b_in));
      else
        m_pre = longint'(b_in);
      m_prod = longint'(a_in) * m_pre;
      if (!in_grp) begin
        grp_len = (len_in == 8'd0) ? 1 : int'(len_in);
        grp_cnt = 0;
        in_grp  = 1'b1;
        for (int i = 0; i < 3; i++) begin
          m_acc[i] = 0; m_ovf[i] = 1'b0; m_held[i] = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!m_held[i]) begin
          m_sum = mode_in[2] ? (m_acc[i] - m_prod) : (m_acc[i] + m_prod);
          if (m_sum > pmax(pw[i]) || m_sum < pmin(pw[i])) begin
            m_ovf[i] = 1'b1;
            if (satv[i]) begin
              m_acc[i]  = (m_sum > 0) ? pmax(pw[i]) : pmin(pw[i]);
              m_held[i] = 1'b1;
            end else begin
              m_acc[i] = wrapw(m_sum, pw[i]);
            end
          end else begin
            m_acc[i] = m_sum;
          end
        end
      end
      grp_cnt++;
      if (grp_cnt == grp_len) begin
        exp_q0.push_back({m_ovf[0], m_acc[0]});
        exp_q1.push_back({m_ovf[1], m_acc[1]});
        exp_q2.push_back({m_ovf[2], m_acc[2]});
        in_grp = 1'b0;
      end
    end

    if (ov0 && out_ready) begin
      obs_p_q.push_back(longint'(p0));
      obs_ovf_q.push_back(ovf0);
      obs_cyc_q.push_back(cyc);
      check64("out48_expected", longint'(exp_q0.size() > 0), 1);
      if (exp_q0.size() > 0) begin
        e0 = exp_q0.pop_front();
        check64("out48_p", p0, longint'(e0[63:0]));
        check64("out48_ovf", ovf0, longint'(e0[64]));
      end
    end
    if (ov1 && out_ready) begin
      last_p1 = p1; last_ovf1 = ovf1;
      check64("sat37_expected", longint'(exp_q1.size() > 0), 1);
      if (exp_q1.size() > 0) begin
        e0 = exp_q1.pop_front();
        check64("sat37_p", p1, longint'(e0[63:0]));
        check64("sat37_ovf", ovf1, longint'(e0[64]));
      end
    end
    if (ov2 && out_ready) begin
      last_p2 = p2; last_ovf2 = ovf2;
      check64("wrap37_expected", longint'(exp_q2.size() > 0), 1);
      if (exp_q2.size() > 0) begin
        e0 = exp_q2.pop_front();
        check64("wrap37_p", p2, longint'(e0[63:0]));
        check64("wrap37_ovf", ovf2, longint'(e0[64]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int a, input int b, input int d, input logic [2:0] mode, input int len);
    int n;
    a_in = 18'(a); b_in = 18'(b); d_in = 18'(d);
    mode_in = mode; len_in = 8'(len); in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check64("send_accept", ir0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check64("drain", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    obs_p_q.delete(); obs_ovf_q.delete(); obs_cyc_q.delete();
    last_p1 = 0; last_p2 = 0; last_ovf1 = 1'b0; last_ovf2 = 1'b0;
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; d_in = '0; mode_in = '0; len_in = '0;
    rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check64("rst_out_valid", ov0, 0);
    check64("rst_p", p0, 0);
    check64("rst_ovf", ovf0, 0);
    check64("rst_in_ready", ir0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check64("post_rst_in_ready", ir0, 1);
    @(posedge clk); #1;

    // single product and latency
    clear_obs();
    send(3, 5, 0, 3'b000, 1);
    wait_drain();
    check64("t1_count", obs_p_q.size(), 1);
    if (obs_p_q.size() == 1) begin
      check64("t1_p", obs_p_q[0], 15);
      check64("t1_ovf", obs_ovf_q[0], 0);
      check64("t1_latency", obs_cyc_q[0] - last_acc_cyc, 4);
    end

    // pre-adder subtract then add
    clear_obs();
    send(-2, 4, 10, 3'b011, 1);
    send(-2, 4, 10, 3'b001, 1);
    wait_drain();
    check64("t2_count", obs_p_q.size(), 2);
    if (obs_p_q.size() == 2) begin
      check64("t2_sub", obs_p_q[0], -12);
      check64("t2_add", obs_p_q[1], -28);
    end

    // back-to-back groups of 4 and 1
    clear_obs();
    for (int i = 1; i <= 4; i++) send(i, 2, 0, 3'b000, 4);
    send(7, 1, 0, 3'b000, 1);
    wait_drain();
    check64("t3_count", obs_p_q.size(), 2);
    if (obs_p_q.size() == 2) begin
      check64("t3_grp4", obs_p_q[0], 20);
      check64("t3_grp1", obs_p_q[1], 7);
      check64("t3_consecutive", obs_cyc_q[1] - obs_cyc_q[0], 1);
    end

    // saturation vs wrap at 37 bits
    clear_obs();
    for (int i = 0; i < 8; i++) send(131071, 131071, 0, 3'b000, 8);
    wait_drain();
    check64("t4_count", obs_p_q.size(), 1);
    if (obs_p_q.size() == 1) begin
      check64("t4_p48", obs_p_q[0], 64'sd137436856328);
      check64("t4_ovf48", obs_ovf_q[0], 0);
    end
    check64("t4_sat_p", last_p1, 64'sd68719476735);
    check64("t4_sat_ovf", last_ovf1, 1);
    check64("t4_wrap_p", last_p2, -64'sd2097144);
    check64("t4_wrap_ovf", last_ovf2, 1);

    // back-pressure while streaming
    clear_obs();
    fork
      begin
        for (int i = 1; i <= 10; i++) send(i, 1, 0, 3'b000, 1);
      end
      begin
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!ov0 && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check64("t5_stall_in_ready", ir0, 0);
          check64("t5_stall_valid", ov0, 1);
          check64("t5_stall_p_hold", p0, (exp_q0.size() > 0) ? longint'(exp_q0[0][63:0]) : -64'sd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check64("t5_count", obs_p_q.size(), 10);
    for (int i = 0; i < obs_p_q.size() && i < 10; i++) check64("t5_order", obs_p_q[i], i + 1);

    // reset in the middle of a group
    send(5, 1, 0, 3'b000, 4);
    send(6, 1, 0, 3'b000, 4);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(negedge clk);
    check64("t6_rst_in_ready", ir0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check64("t6_out_valid", ov0, 0);
    check64("t6_p", p0, 0);
    check64("t6_ovf", ovf0, 0);
    check64("t6_in_ready", ir0, 1);
    @(posedge clk); #1;
    clear_obs();
    for (int i = 1; i <= 4; i++) send(i, 1, 0, 3'b000, 4);
    wait_drain();
    check64("t6_count", obs_p_q.size(), 1);
    if (obs_p_q.size() == 1) check64("t6_p_new_group", obs_p_q[0], 10);

    // random stream with random back-pressure, checked by the model
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
          end
          send(rnd18(), rnd18(), rnd18(), 3'($urandom_range(0, 7)), $urandom_range(0, 6));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    // close any open group so every accepted product is accounted for
    if (in_grp) begin
      while (in_grp) send(1, 1, 0, 3'b000, 1);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
